// File: rtl/controle_busca_pkg.sv
// Shared definitions for the instruction-fetch controller and its fetch buffer.
// Memory size and word width defaults are also used by the instruction memory.
package pkg_controle;

   typedef enum logic [1:0] {
      OCIOSO,
      BUSCA,
      FIM
   } estado_t;

   localparam int PROF_FILA      = 2;
   localparam int LARG_CONT      = $clog2(PROF_FILA + 1);
   localparam int LARG_IDX       = $clog2(PROF_FILA);
   localparam int TAM_MEM_PADRAO = 12;
   localparam int LARG_PADRAO    = 32;

endpackage

// File: rtl/controle_busca_if.sv
// Fetch-side bundle: start/branch controls, instruction memory port and decode handshake.
interface controle_busca_if
   import pkg_controle::*;
#(
   parameter int LARG = LARG_PADRAO
) ();

   logic            Inicio;
   logic [LARG-1:0] PC;
   logic [LARG-1:0] Instrucao;
   logic            Desvio;
   logic [LARG-1:0] AlvoDesvio;
   logic            InstrValida;
   logic            InstrPronta;
   logic [LARG-1:0] InstrSaida;
   logic [LARG-1:0] PCSaida;
   logic            Concluido;
   logic            ErroEndereco;

   // master is the fetch controller, slave is the surrounding core and memory
   modport master (
      input  Inicio, Instrucao, Desvio, AlvoDesvio, InstrPronta,
      output PC, InstrValida, InstrSaida, PCSaida, Concluido, ErroEndereco
   );

   modport slave (
      output Inicio, Instrucao, Desvio, AlvoDesvio, InstrPronta,
      input  PC, InstrValida, InstrSaida, PCSaida, Concluido, ErroEndereco
   );

endinterface

// File: rtl/controle_busca_fila.sv
// Shift-style FIFO of {PC, instruction}; entry 0 is always the head, so the head is a plain register.
module fila_busca
   import pkg_controle::*;
#(
   parameter int LARG = LARG_PADRAO
) (
   input  logic                 Clock,
   input  logic                 ResetN,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 flush,
   input  logic [LARG-1:0]      pcEntrada,
   input  logic [LARG-1:0]      instrEntrada,
   output logic [LARG-1:0]      pcCabeca,
   output logic [LARG-1:0]      instrCabeca,
   output logic [LARG_CONT-1:0] count,
   output logic                 cheia,
   output logic                 vazia
);

   logic [LARG-1:0]     pcFila    [PROF_FILA];
   logic [LARG-1:0]     instrFila [PROF_FILA];
   logic [LARG_IDX-1:0] slot;

   // A simultaneous pop shifts everything down one slot, so the new word lands one lower
   always_comb begin
      slot = LARG_IDX'(count);
      if (pop) begin
         slot = LARG_IDX'(count - LARG_CONT'(1));
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         count <= '0;
         for (int i = 0; i < PROF_FILA; i++) begin
            pcFila[i]    <= '0;
            instrFila[i] <= '0;
         end
      end else if (flush) begin
         count <= '0;
      end else begin
         if (pop) begin
            for (int i = 0; i < PROF_FILA - 1; i++) begin
               pcFila[i]    <= pcFila[i+1];
               instrFila[i] <= instrFila[i+1];
            end
         end
         if (push) begin
            pcFila[slot]    <= pcEntrada;
            instrFila[slot] <= instrEntrada;
         end
         count <= count + LARG_CONT'(push) - LARG_CONT'(pop);
      end
   end

   assign pcCabeca    = pcFila[0];
   assign instrCabeca = instrFila[0];
   assign cheia       = (count == LARG_CONT'(PROF_FILA));
   assign vazia       = (count == '0);

endmodule

// File: rtl/controle_busca.sv
// Instruction-fetch controller: owns the PC, fills the fetch buffer from a combinational
// instruction memory, applies branch redirects and flags end-of-program.
module controle_busca
   import pkg_controle::*;
#(
   parameter int TAM_MEM = TAM_MEM_PADRAO,
   parameter int LARG    = LARG_PADRAO
) (
   input logic               Clock,
   input logic               ResetN,
   controle_busca_if.master  bus
);

   estado_t              estado;
   logic [LARG-1:0]      pc;
   logic                 erro;
   logic                 push;
   logic                 pop;
   logic                 flush;
   logic                 alvoValido;
   logic [LARG_CONT-1:0] contagem;
   logic                 cheia;
   logic                 vazia;

   // A redirect outranks everything once running; a pop in that same cycle still completes
   assign pop        = !vazia && bus.InstrPronta;
   assign flush      = bus.Desvio && (estado != OCIOSO);
   assign push       = (estado == BUSCA) && !flush && (!cheia || pop);
   assign alvoValido = (bus.AlvoDesvio < LARG'(TAM_MEM));

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         estado <= OCIOSO;
         pc     <= '0;
         erro   <= 1'b0;
      end else if (estado == OCIOSO) begin
         if (bus.Inicio) begin
            estado <= BUSCA;
         end
      end else if (flush) begin
         pc <= bus.AlvoDesvio;
         if (alvoValido) begin
            estado <= BUSCA;
         end else begin
            estado <= FIM;
            erro   <= 1'b1;
         end
      end else if (push) begin
         pc <= pc + LARG'(1);
         if (pc == LARG'(TAM_MEM - 1)) begin
            estado <= FIM;
         end
      end
   end

   fila_busca #(
      .LARG (LARG)
   ) u_fila (
      .Clock        (Clock),
      .ResetN       (ResetN),
      .push         (push),
      .pop          (pop),
      .flush        (flush),
      .pcEntrada    (pc),
      .instrEntrada (bus.Instrucao),
      .pcCabeca     (bus.PCSaida),
      .instrCabeca  (bus.InstrSaida),
      .count        (contagem),
      .cheia        (cheia),
      .vazia        (vazia)
   );

   assign bus.PC           = pc;
   assign bus.InstrValida  = !vazia;
   assign bus.Concluido    = (estado == FIM) && (contagem == '0);
   assign bus.ErroEndereco = erro;

endmodule

// File: tb/tb_controle_busca.sv
// Self-checking bench for controle_busca: queue-based fetch model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_controle_busca;
   import pkg_controle::*;

   localparam int TAM = 12;
   localparam int W   = 32;

   localparam int PARADO    = 0;
   localparam int BUSCANDO  = 1;
   localparam int ENCERRADO = 2;

   typedef struct packed {
      logic [W-1:0] pc;
      logic [W-1:0] instr;
   } entrada_t;

   logic Clock  = 1'b0;
   logic ResetN = 1'b1;

   controle_busca_if #(.LARG(W)) bus ();

   controle_busca #(
      .TAM_MEM (TAM),
      .LARG    (W)
   ) dut (
      .Clock  (Clock),
      .ResetN (ResetN),
      .bus    (bus)
   );

   always #5 Clock = ~Clock;

   logic [W-1:0] memoria [TAM];

   function automatic int clampIdx(input logic [W-1:0] p);
      return (p >= W'(TAM)) ? TAM - 1 : int'(p);
   endfunction

   always_comb bus.Instrucao = memoria[clampIdx(bus.PC)];

   int total = 0;
   int bad   = 0;

   task automatic checkOutput(input string nome, input logic [W-1:0] atual, input logic [W-1:0] esperado);
      total++;
      if (atual !== esperado) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
      end
   endtask

   // Reference model: a queue of fetched words plus a running/done flag
   entrada_t     fila[$];
   int           mEstado  = PARADO;
   logic [W-1:0] mPc      = '0;
   bit           mErro    = 1'b0;
   bit           mPop     = 1'b0;
   int           mTransf  = 0;
   int           dutTransf = 0;

   always @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         fila.delete();
         mEstado = PARADO;
         mPc     = '0;
         mErro   = 1'b0;
      end else begin
         mPop = (fila.size() > 0) && bus.InstrPronta;
         if (mPop) begin
            void'(fila.pop_front());
            mTransf++;
         end
         if (mEstado == PARADO) begin
            if (bus.Inicio) mEstado = BUSCANDO;
         end else if (bus.Desvio) begin
            fila.delete();
            mPc = bus.AlvoDesvio;
            if (bus.AlvoDesvio < TAM) begin
               mEstado = BUSCANDO;
            end else begin
               mEstado = ENCERRADO;
               mErro   = 1'b1;
            end
         end else if (mEstado == BUSCANDO && fila.size() < PROF_FILA) begin
            fila.push_back('{pc: mPc, instr: memoria[clampIdx(mPc)]});
            if (mPc == W'(TAM - 1)) mEstado = ENCERRADO;
            mPc = mPc + 1;
         end
      end
   end

   always @(negedge Clock) begin
      if (ResetN) begin
         if (bus.InstrValida && bus.InstrPronta) dutTransf++;
         checkOutput("pc", bus.PC, mPc);
         checkOutput("valida", W'(bus.InstrValida), W'(fila.size() > 0));
         if (fila.size() > 0) begin
            checkOutput("instrSaida", bus.InstrSaida, fila[0].instr);
            checkOutput("pcSaida", bus.PCSaida, fila[0].pc);
         end
         checkOutput("concluido", W'(bus.Concluido), W'(mEstado == ENCERRADO && fila.size() == 0));
         checkOutput("erro", W'(bus.ErroEndereco), W'(mErro));
      end
   end

   task automatic tick();
      @(posedge Clock);
      #2;
   endtask

   task automatic applyStimulus(input bit inicio, input bit desvio, input logic [W-1:0] alvo, input bit pronta);
      bus.Inicio      = inicio;
      bus.Desvio      = desvio;
      bus.AlvoDesvio  = alvo;
      bus.InstrPronta = pronta;
   endtask

   // Asserts reset between edges, checks the immediate reset values, then releases after an edge
   task automatic applyReset();
      #1 ResetN = 1'b0;
      #1;
      checkOutput("rst pc", bus.PC, '0);
      checkOutput("rst valida", W'(bus.InstrValida), '0);
      checkOutput("rst instrSaida", bus.InstrSaida, '0);
      checkOutput("rst pcSaida", bus.PCSaida, '0);
      checkOutput("rst concluido", W'(bus.Concluido), '0);
      checkOutput("rst erro", W'(bus.ErroEndereco), '0);
      @(posedge Clock);
      #2 ResetN = 1'b1;
   endtask

   task automatic startRun();
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      tick();
   endtask

   initial begin
      for (int i = 0; i < TAM; i++) begin
         memoria[i] = ($urandom() & 32'hFFFF_FF00) | W'(i);
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      applyReset();

      // Straight-line run: head PCs 0..11 on consecutive cycles from cycle 2
      startRun();
      for (int k = 0; k < TAM; k++) begin
         checkOutput("linha valida", W'(bus.InstrValida), 1);
         checkOutput("linha pcSaida", bus.PCSaida, W'(k));
         checkOutput("linha instr", bus.InstrSaida, memoria[k]);
         tick();
      end
      checkOutput("linha concluido", W'(bus.Concluido), 1);
      checkOutput("linha valida fim", W'(bus.InstrValida), 0);
      checkOutput("linha pc fim", bus.PC, W'(TAM));

      // Backpressure: buffer fills, PC parks at 2, release resumes without gaps
      applyReset();
      startRun();
      checkOutput("bp pcSaida0", bus.PCSaida, 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      tick(); tick(); tick();
      checkOutput("bp pc parado", bus.PC, 2);
      checkOutput("bp cabeca", bus.PCSaida, 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checkOutput("bp retomada", bus.PCSaida, W'(k));
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      tick(); tick();

      // Branch with two entries buffered
      applyStimulus(1'b0, 1'b1, 5, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("desvio valida0", W'(bus.InstrValida), 0);
      checkOutput("desvio pc", bus.PC, 5);
      tick();
      checkOutput("desvio valida1", W'(bus.InstrValida), 1);
      checkOutput("desvio pcSaida", bus.PCSaida, 5);

      // Pop and branch in the same cycle: only the target follows
      applyStimulus(1'b0, 1'b1, 9, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("pop+desvio valida0", W'(bus.InstrValida), 0);
      tick();
      checkOutput("pop+desvio pcSaida", bus.PCSaida, 9);

      // Out-of-range target: sticky error, immediate completion, later recovery
      applyStimulus(1'b0, 1'b1, 20, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("fora erro", W'(bus.ErroEndereco), 1);
      checkOutput("fora concluido", W'(bus.Concluido), 1);
      checkOutput("fora pc", bus.PC, 20);
      tick(); tick();
      checkOutput("fora erro fixo", W'(bus.ErroEndereco), 1);
      applyStimulus(1'b0, 1'b1, 3, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("retorno concluido", W'(bus.Concluido), 0);
      tick();
      checkOutput("retorno pcSaida", bus.PCSaida, 3);
      checkOutput("retorno erro", W'(bus.ErroEndereco), 1);

      // Mid-run asynchronous reset, then idle until started again
      applyReset();
      tick(); tick(); tick();
      checkOutput("ocioso valida", W'(bus.InstrValida), 0);
      checkOutput("ocioso pc", bus.PC, 0);
      startRun();
      checkOutput("reinicio pcSaida", bus.PCSaida, 0);
      checkOutput("reinicio valida", W'(bus.InstrValida), 1);

      // Randomized traffic checked against the model every cycle
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            applyReset();
         end else begin
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                          W'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            tick();
         end
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      tick();
      checkOutput("transferencias", W'(dutTransf), W'(mTransf));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controle_busca.md
# controle_busca

Instruction-fetch controller for the MIPS core. It owns the program counter and sequences reads from the instruction memory, which is word-indexed and combinational with a clamped index range. Fetched words pass to decode through a 2-entry buffer with a valid/ready handshake. The block also applies branch redirects from the execute stage and reports end-of-program.

## Interface

Parameters:
- TAM_MEM, 12: number of instruction words in instruction memory; valid indices 0..TAM_MEM-1.
- LARG, 32: instruction and PC width.

Ports:
- Clock  in  1  single system clock; all state changes on its rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Inicio  in  1  one-cycle start pulse; honoured only in OCIOSO.
- PC  out  LARG  word index driven to instruction memory.
- Instrucao  in  LARG  memory read data, combinational from PC in the same cycle.
- Desvio  in  1  branch taken; redirect this cycle.
- AlvoDesvio  in  LARG  branch target word index; sampled when Desvio=1.
- InstrValida  out  1  buffer head holds a valid instruction.
- InstrPronta  in  1  decode accepts the head.
- InstrSaida  out  LARG  head instruction word.
- PCSaida  out  LARG  PC of the head instruction.
- Concluido  out  1  state is FIM and the buffer is empty.
- ErroEndereco  out  1  sticky; a branch target was ≥ TAM_MEM.

## Operation

- States: OCIOSO, BUSCA, FIM. Reset enters OCIOSO.
- **OCIOSO:** PC held at 0 and no writes to the buffer. Inicio=1 moves to BUSCA.
- **BUSCA, push condition:** count<2, or count=2 with a pop in the same cycle.
  - On push: write {PC, Instrucao} to the buffer and set PC←PC+1.
  - If the pushed PC equals TAM_MEM-1, go to FIM. PC still increments.
  - When push is not allowed, PC holds.
- **FIM:** no pushes. The buffer drains normally.
- **Pop:** occurs when InstrValida and InstrPronta are both 1. The head advances.
- **Desvio=1:** highest priority, accepted in any state except OCIOSO.
  - The buffer is flushed (count←0).
  - A pop in the same cycle still counts as a completed transfer.
  - No push occurs that cycle.
  - If AlvoDesvio < TAM_MEM: PC←AlvoDesvio and state←BUSCA. A redirect from FIM resumes fetching.
  - Else: ErroEndereco←1, PC←AlvoDesvio and state←FIM.
- Desvio and Inicio in OCIOSO: Desvio is ignored and Inicio wins.
- ErroEndereco is cleared only by reset.
- PC arithmetic is unsigned LARG-bit with natural wrap. Wrap cannot be reached in normal flow because FIM stops at TAM_MEM-1.

## Timing

- Reset values (asynchronous, immediate on ResetN=0):
  - PC=0, InstrSaida=0, PCSaida=0.
  - InstrValida=0, Concluido=0, ErroEndereco=0.
  - Buffer count=0 and entries zeroed. State=OCIOSO.
- Reset mid-operation discards all buffered entries. No partial transfer is reported.
- Start latency:
  - Inicio is sampled at edge 0, giving BUSCA in cycle 1.
  - The first push happens at edge 1.
  - InstrValida=1 in cycle 2 with PCSaida=0.
- Throughput: one instruction per cycle while InstrPronta=1.
- Redirect latency:
  - Desvio is sampled at edge N.
  - The target is pushed at edge N+1.
  - It is valid at the head in cycle N+2.
  - InstrValida=0 in cycle N+1.
- Buffer outputs InstrSaida, PCSaida and InstrValida are register outputs, with no combinational path from inputs.
- PC feeds the memory and Instrucao returns within the same cycle. The memory path is single-cycle combinational.
- Concluido rises the cycle after the last pop in FIM.

## Structure

- Shared package pkg_controle holds:
  - the state enum {OCIOSO, BUSCA, FIM};
  - the buffer depth constant PROF_FILA=2;
  - TAM_MEM and LARG defaults, shared with the instruction memory.
- Sub-module fila_busca: a 2-entry synchronous FIFO of {PC, instruction}.
  - Inputs: push, pop and flush, where flush overrides push.
  - Outputs: count, cheia and vazia.
- The FSM and PC register live in controle_busca.

## Test plan

- **Straight-line run:** reset, pulse Inicio, hold InstrPronta=1.
  - PCSaida is 0..11 on consecutive cycles starting in cycle 2.
  - FIM is reached after PC 11 is pushed.
  - Concluido=1 one cycle after the last pop.
- **Backpressure:** InstrPronta=0 from cycle 2.
  - The buffer fills to 2 and PC holds at 2.
  - Releasing InstrPronta resumes at PC 2 with no lost or duplicated words.
- **Branch:** Desvio=1 with AlvoDesvio=5 while 2 entries are buffered.
  - The buffer flushes and InstrValida=0 in the next cycle.
  - The cycle after that shows PCSaida=5.
- **Branch out of range:** AlvoDesvio=20.
  - ErroEndereco=1 sticks and the state goes to FIM.
  - Concluido=1 the next cycle.
  - A later Desvio with AlvoDesvio=3 resumes fetch at 3 while ErroEndereco stays 1.
- **Simultaneous events:**
  - Pop with Desvio in the same cycle: the head is counted as transferred once and nothing else is delivered.
  - Push with pop at count=2: count stays at 2.
- **Asynchronous reset mid-run:** assert ResetN=0 between clock edges.
  - Outputs go to their reset values immediately.
  - The block waits in OCIOSO until Inicio.
